// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_control encodings, RV32 opcode constants and the
// ID/EX buffer state type. Used by the decode stage and by the ALU itself.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // alt selects SUB over ADD and SRA over SRL; callers pass 0 where no alternate exists.
  function automatic alu_ctrl_e f3_to_ctrl(input logic [2:0] f3, input logic alt);
    alu_ctrl_e c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-op decode (OP, OP-IMM, LUI, AUIPC).
// ALU_CTRL_ILLEGAL_EN exposes the illegal flag; otherwise it is tied low.
module alu_op_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);
  import alu_pkg::*;

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [11:0] imm_i;
  logic signed [31:0] imm_u;
  logic               ill;
  alu_ctrl_e          ctrl;
  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;

  always_comb begin
    opcode = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    imm_i  = instr[31:20];
    imm_u  = {instr[31:12], 12'b0};
    ill    = 1'b0;
    ctrl   = ALU_ADD;
    a      = '0;
    b      = '0;
    case (opcode)
      OPC_OP: begin
        a    = rs1_data;
        b    = rs2_data;
        ctrl = f3_to_ctrl(f3, f7[5]);
        ill  = !((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        a = rs1_data;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          b    = XLEN'(instr[24:20]);
          ctrl = f3_to_ctrl(f3, f7[5]);
          ill  = !((f7 == F7_BASE) || ((f3 == 3'b101) && (f7 == F7_ALT)));
        end else begin
          b    = XLEN'(imm_i);
          ctrl = f3_to_ctrl(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        b = XLEN'(imm_u);
      end
      OPC_AUIPC: begin
        a = pc;
        b = XLEN'(imm_u);
      end
      default: ill = 1'b1;
    endcase

    // Illegal encodings leave the EX stage a harmless NOP.
    if (ill) begin
      ctrl = ALU_ADD;
      a    = '0;
      b    = '0;
    end
  end

  assign alu_a       = a;
  assign alu_b       = b;
  assign alu_control = ctrl;
  assign rd          = instr[11:7];
  assign reg_write   = !ill && (instr[11:7] != 5'd0);

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal = ill;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX boundary: decodes ALU control and holds results in a 2-entry
// output+skid buffer with registered in_ready (decode honours ALU_CTRL_ILLEGAL_EN).
module id_ex_alu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            flush,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);
  import alu_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [4:0]      rd;
    logic            rw;
    logic            ill;
  } entry_t;

  entry_t     dec_e;
  entry_t     out_q, out_d;
  entry_t     skid_q, skid_d;
  buf_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept, retire;

  alu_op_decode #(.XLEN(XLEN)) u_dec (
    .instr       (instr),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_a       (dec_e.a),
    .alu_b       (dec_e.b),
    .alu_control (dec_e.ctrl),
    .rd          (dec_e.rd),
    .reg_write   (dec_e.rw),
    .illegal     (dec_e.ill)
  );

  assign accept = in_valid && in_ready_q;
  assign retire = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (accept) state_d = BUF_ONE;
      BUF_ONE: begin
        if (accept && !retire)      state_d = BUF_TWO;
        else if (!accept && retire) state_d = BUF_EMPTY;
      end
      BUF_TWO: if (retire) state_d = BUF_ONE;
      default: state_d = BUF_EMPTY;
    endcase
    if (flush) state_d = BUF_EMPTY;
  end

  // Payload movement; a flush freezes the registers and lets out_valid drop.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        BUF_EMPTY: if (accept) out_d = dec_e;
        BUF_ONE: begin
          if (accept && retire) out_d  = dec_e;
          else if (accept)      skid_d = dec_e;
        end
        BUF_TWO: if (retire) out_d = skid_q;
        default: ;
      endcase
    end
    out_valid_d = (state_d != BUF_EMPTY);
    in_ready_d  = (state_d != BUF_TWO);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alu_a       = out_q.a;
  assign alu_b       = out_q.b;
  assign alu_control = out_q.ctrl;
  assign rd          = out_q.rd;
  assign reg_write   = out_q.rw;
  assign illegal     = out_q.ill;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: directed cases then randomized traffic against a
// queue-based FIFO model with an arithmetic decode reference.
module tb_id_ex_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } ent_t;

  ent_t q[$];

  // funct3 -> base ALU code; the alternate form (SUB/SRA) is base + 1.
  localparam int BASE [8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  id_ex_alu_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .rd          (rd),
    .reg_write   (reg_write),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
    ent_t e;
    logic ok;
    logic alt;
    int   f3;
    f3  = int'(ins[14:12]);
    alt = (ins[31:25] == 7'h20);
    ok  = 1'b1;
    e   = '0;
    case (ins[6:0])
      7'h33: begin
        ok  = (ins[31:25] == 7'h00) || (alt && (f3 == 0 || f3 == 5));
        e.c = 4'(BASE[f3] + (alt ? 1 : 0));
        e.a = r1;
        e.b = r2;
      end
      7'h13: begin
        e.a = r1;
        if (f3 == 1 || f3 == 5) begin
          ok  = (ins[31:25] == 7'h00) || (alt && f3 == 5);
          e.c = 4'(BASE[f3] + (alt ? 1 : 0));
          e.b = {27'b0, ins[24:20]};
        end else begin
          e.c = 4'(BASE[f3]);
          e.b = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'h37: e.b = {ins[31:12], 12'b0};
      7'h17: begin
        e.a = p;
        e.b = {ins[31:12], 12'b0};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.a = 32'd0;
      e.b = 32'd0;
      e.c = 4'd0;
    end
    e.rd = ins[11:7];
    e.rw = ok && (ins[11:7] != 5'd0);
`ifdef ALU_CTRL_ILLEGAL_EN
    e.ill = !ok;
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 6)
      0, 1:    r[6:0] = 7'h33;
      2, 3:    r[6:0] = 7'h13;
      4:       r[6:0] = ($urandom % 2 == 0) ? 7'h37 : 7'h17;
      default: r[6:0] = 7'($urandom);
    endcase
    case ($urandom % 3)
      0:       r[31:25] = 7'h00;
      1:       r[31:25] = 7'h20;
      default: r[31:25] = 7'($urandom);
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    if (q.size() > 0)
      chk("payload", 128'({alu_a, alu_b, alu_control, rd, reg_write, illegal}), 128'(q[0]));
  endtask

  // Advance the model with the pre-edge inputs, clock once, then compare.
  task automatic tick();
    ent_t e;
    logic ret;
    logic acc;
    e = ref_dec(instr, pc, rs1_data, rs2_data);
    if (rst || flush) begin
      q.delete();
    end else begin
      ret = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2);
    in_valid = v;
    instr    = ins;
    pc       = $urandom;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  function automatic logic [31:0] addi_rd(input logic [4:0] d);
    return {12'h001, 5'd0, 3'b000, d, 7'h13};
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
    tick();
    tick();
    chk("rst_payload", 128'({alu_a, alu_b, alu_control, rd, reg_write, illegal}), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();

    // add x3,x1,x2
    out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd10, 32'd5);
    tick();
    chk("add_vld", 128'(out_valid), 128'd1);
    chk("add_ops", 128'({alu_control, alu_a, alu_b, rd, reg_write}), 128'({4'd0, 32'd10, 32'd5, 5'd3, 1'b1}));
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();

    // sub x3,x1,x2
    drive(1'b1, 32'h402081B3, 32'd10, 32'd10);
    tick();
    chk("sub_ops", 128'({alu_control, alu_a, alu_b}), 128'({4'd1, 32'd10, 32'd10}));
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();

    // srai x5,x6,2
    drive(1'b1, 32'h40235293, 32'hFFFFFFF8, 32'h1234);
    tick();
    chk("srai_ops", 128'({alu_control, alu_b, rd}), 128'({4'd7, 32'd2, 5'd5}));
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();

    // Backpressure: three back-to-back, third held upstream.
    out_ready = 1'b0;
    drive(1'b1, addi_rd(5'd1), 32'd7, 32'd0);
    tick();
    drive(1'b1, addi_rd(5'd2), 32'd8, 32'd0);
    tick();
    chk("bp_full", 128'(in_ready), 128'd0);
    drive(1'b1, addi_rd(5'd3), 32'd9, 32'd0);
    tick();
    chk("bp_hold", 128'({in_ready, rd}), 128'({1'b0, 5'd1}));
    out_ready = 1'b1;
    tick();
    chk("bp_second", 128'({out_valid, rd}), 128'({1'b1, 5'd2}));
    tick();
    chk("bp_third", 128'({out_valid, rd}), 128'({1'b1, 5'd3}));
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("bp_drain", 128'(out_valid), 128'd0);

    // Flush from TWO with a concurrent input.
    out_ready = 1'b0;
    drive(1'b1, addi_rd(5'd4), 32'd1, 32'd0);
    tick();
    drive(1'b1, addi_rd(5'd5), 32'd2, 32'd0);
    tick();
    flush = 1'b1;
    drive(1'b1, addi_rd(5'd6), 32'd3, 32'd0);
    tick();
    chk("flush_state", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("flush_absent", 128'(out_valid), 128'd0);

    // Unknown opcode.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000007F, 32'd11, 32'd12);
    tick();
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("illegal_op", 128'({out_valid, illegal, reg_write}), 128'({1'b1, 1'b1, 1'b0}));
`else
    chk("illegal_op", 128'({out_valid, illegal, alu_control, reg_write}), 128'({1'b1, 1'b0, 4'd0, 1'b0}));
`endif
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();

    // Randomized traffic with occasional flush and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, rnd_instr(), $urandom, $urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      rst       = (i == 200);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_ctrl.md
ID_EX_ALU_CTRL -- requirements
Module: id_ex_alu_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: in_valid  in  1 / in_ready  out  1  upstream handshake.
REQ-005 SHALL have ports: instr  in  32 / pc, rs1_data, rs2_data  in  XLEN  decode-stage payload.
REQ-006 SHALL have ports: out_valid  out  1 / out_ready  in  1  downstream (EX) handshake.
REQ-007 SHALL have ports: flush  in  1  discard all held entries.
REQ-008 SHALL have ports: alu_a, alu_b  out  XLEN; alu_control  out  4; rd  out  5; reg_write  out  1; illegal  out  1.

Function
REQ-009 SHALL decode OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111); all other opcodes are illegal.
REQ-010 SHALL emit alu_control: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-011 SHALL map funct3: 000 ADD (SUB only for OP with funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND.
REQ-012 SHALL flag illegal: OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM shift with funct7 not 0000000 (SLL/SRL) or 0100000 (SRA).
REQ-013 SHALL drive alu_a=rs1_data and alu_b=rs2_data (OP); alu_b=sign-extended I-imm (OP-IMM), zero-extended instr[24:20] for shifts.
REQ-014 SHALL drive LUI: alu_a=0, alu_b={instr[31:12],12'b0}, ADD; AUIPC: alu_a=pc, same alu_b, ADD.
REQ-015 SHALL drive rd=instr[11:7]; reg_write=legal AND rd!=0; illegal entries: alu_control=ADD, alu_a=alu_b=0.
REQ-016 SHALL hold a 2-entry buffer (output register + skid register); states EMPTY, ONE, TWO.
REQ-017 SHALL accept when in_valid AND in_ready; in_ready is registered and equals (state!=TWO).
REQ-018 SHALL present a decoded entry on outputs exactly 1 cycle after acceptance into EMPTY.
REQ-019 SHALL retire output entry when out_valid AND out_ready; skid entry moves to output same edge.
REQ-020 SHALL handle simultaneous accept and retire in ONE by staying ONE; in TWO accept is impossible.
REQ-021 SHALL preserve strict FIFO order; no entry dropped or duplicated under any backpressure.
REQ-022 SHALL on flush go to EMPTY next edge, dropping held entries and any same-cycle input; flush has priority over accept and retire.
REQ-023 SHALL hold output payload stable while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL on rst: state EMPTY, out_valid=0, in_ready=1, alu_a=alu_b=0, alu_control=0000, rd=0, reg_write=0, illegal=0.
REQ-025 SHALL treat rst mid-operation as flush; rst overrides flush and all handshakes.

Configuration
REQ-026 SHALL with ALU_CTRL_ILLEGAL_EN defined: drive illegal per REQ-012/REQ-009.
REQ-027 SHALL without ALU_CTRL_ILLEGAL_EN: tie illegal=0 and decode illegal instructions as NOP (ADD, operands 0, reg_write=0).

Structure
REQ-028 SHALL place alu_control encodings, opcode constants and buffer-state typedef in shared package alu_pkg, used also by the ALU.
REQ-029 SHALL factor the combinational decode into sub-module alu_op_decode; buffering stays in id_ex_alu_ctrl.

Verification
REQ-030 SHALL test instr=0x002081B3 (add x3,x1,x2), rs1=10, rs2=5 -> next cycle out_valid=1, alu_control=0000, alu_a=10, alu_b=5, rd=3, reg_write=1.
REQ-031 SHALL test instr=0x402081B3, rs1=10, rs2=10 -> alu_control=0001, alu_a=10, alu_b=10.
REQ-032 SHALL test instr=0x40235293 (srai x5,x6,2), rs1=0xFFFFFFF8 -> alu_control=0111, alu_b=2, rd=5.
REQ-033 SHALL test out_ready=0, three back-to-back inputs -> in_ready=0 after second accept, third held upstream; then out_ready=1 -> all three emerge in order.
REQ-034 SHALL test flush with state TWO and in_valid=1 -> next cycle out_valid=0, in_ready=1, concurrent input absent.
REQ-035 SHALL test instr=0x0000007F -> with macro illegal=1, reg_write=0; without macro illegal=0, alu_control=0000, reg_write=0.
